// File: rtl/zir_pkg.sv
// Shared definitions for the IR frame upload receiver: FSM encoding,
// header bytes and error codes.
package zir_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC2,
    ST_PIX_HI,
    ST_PIX_LO,
    ST_CHKSUM
  } state_t;

  localparam logic [7:0] SYNC_B0 = 8'h55;
  localparam logic [7:0] SYNC_B1 = 8'hAA;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/zir_rx_watchdog.sv
// Inter-byte idle watchdog: counts armed cycles without a kick and pulses
// expire on the cycle the idle count reaches TIMEOUT_CYC.
module zir_rx_watchdog #(
  parameter int TIMEOUT_CYC = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arm,
  input  logic kick,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_reg;

  // cnt_reg holds idle cycles already elapsed, so the current idle cycle is
  // number cnt_reg+1; a kick in the same cycle always wins.
  assign expire = arm && !kick && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (!arm || kick || expire) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/zir_frame_receiver.sv
// IR frame upload receiver: hunts the 0x55 0xAA header, reassembles 16-bit
// pixels with line/frame markers and verifies the trailing checksum byte.
module zir_frame_receiver
  import zir_pkg::*;
#(
  parameter int PIX_PER_LINE = 256,
  parameter int LINES        = 192,
  parameter int TIMEOUT_CYC  = 250000
) (
  input  logic        iClk,
  input  logic        iRst_N,
  input  logic        iEn,
  input  logic [7:0]  iRxData,
  input  logic        iRxRdy,
  output logic [15:0] oPixData,
  output logic        oPixValid,
  output logic        oLineEnd,
  output logic        oFrameEnd,
  output logic        oFrameDone,
  output logic        oFrameErr,
  output logic [1:0]  oErrCode,
  output logic        oBusy
);

  localparam int COL_W = (PIX_PER_LINE > 1) ? $clog2(PIX_PER_LINE) : 1;
  localparam int ROW_W = (LINES > 1) ? $clog2(LINES) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(PIX_PER_LINE - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(LINES - 1);

  state_t           state_reg, state_next;
  logic [COL_W-1:0] col_reg;
  logic [ROW_W-1:0] row_reg;
  logic [7:0]       csum_reg;
  logic [7:0]       hi_reg;
  logic             last_col, last_row;
  logic             wd_arm, wd_expire;

  assign last_col = (col_reg == COL_LAST);
  assign last_row = (row_reg == ROW_LAST);
  assign wd_arm   = (state_reg != ST_IDLE) && iEn;
  assign oBusy    = (state_reg != ST_IDLE);

  zir_rx_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (iClk),
    .rst_n  (iRst_N),
    .arm    (wd_arm),
    .kick   (iRxRdy),
    .expire (wd_expire)
  );

  always_ff @(posedge iClk or negedge iRst_N) begin
    if (!iRst_N) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (!iEn) begin
      state_next = ST_IDLE;
    end else if (iRxRdy) begin
      case (state_reg)
        ST_IDLE: begin
          if (iRxData == SYNC_B0) state_next = ST_SYNC2;
        end
        ST_SYNC2: begin
          if (iRxData == SYNC_B1)      state_next = ST_PIX_HI;
          else if (iRxData != SYNC_B0) state_next = ST_IDLE;
        end
        ST_PIX_HI: state_next = ST_PIX_LO;
        ST_PIX_LO: state_next = (last_col && last_row) ? ST_CHKSUM : ST_PIX_HI;
        ST_CHKSUM: state_next = ST_IDLE;
        default:   state_next = ST_IDLE;
      endcase
    end else if (wd_expire) begin
      state_next = ST_IDLE;
    end
  end

  always_ff @(posedge iClk or negedge iRst_N) begin
    if (!iRst_N) begin
      col_reg    <= '0;
      row_reg    <= '0;
      csum_reg   <= '0;
      hi_reg     <= '0;
      oPixData   <= '0;
      oPixValid  <= 1'b0;
      oLineEnd   <= 1'b0;
      oFrameEnd  <= 1'b0;
      oFrameDone <= 1'b0;
      oFrameErr  <= 1'b0;
      oErrCode   <= ERR_NONE;
    end else begin
      oPixValid  <= 1'b0;
      oLineEnd   <= 1'b0;
      oFrameEnd  <= 1'b0;
      oFrameDone <= 1'b0;
      oFrameErr  <= 1'b0;
      if (!iEn) begin
        col_reg  <= '0;
        row_reg  <= '0;
        csum_reg <= '0;
      end else if (iRxRdy) begin
        case (state_reg)
          ST_SYNC2: begin
            if (iRxData == SYNC_B1) begin
              col_reg  <= '0;
              row_reg  <= '0;
              csum_reg <= '0;
              oErrCode <= ERR_NONE;
            end
          end
          ST_PIX_HI: begin
            hi_reg   <= iRxData;
            csum_reg <= csum_reg + iRxData;
          end
          ST_PIX_LO: begin
            oPixData  <= {hi_reg, iRxData};
            oPixValid <= 1'b1;
            oLineEnd  <= last_col;
            oFrameEnd <= last_col && last_row;
            csum_reg  <= csum_reg + iRxData;
            if (last_col) begin
              col_reg <= '0;
              row_reg <= last_row ? '0 : row_reg + 1'b1;
            end else begin
              col_reg <= col_reg + 1'b1;
            end
          end
          ST_CHKSUM: begin
            if (iRxData == csum_reg) begin
              oFrameDone <= 1'b1;
            end else begin
              oFrameErr <= 1'b1;
              oErrCode  <= ERR_CSUM;
            end
          end
          default: ;
        endcase
      end else if (wd_expire) begin
        oFrameErr <= 1'b1;
        oErrCode  <= ERR_TIMEOUT;
      end
    end
  end

endmodule
